// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies, FSM state type.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MDU_MUL_LAT = 5;
  localparam int MDU_DIV_LAT = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit product or quotient/remainder for the E-stage op.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               signed_div;
  logic [31:0]        mag_a, mag_b, num, den, den_safe, quo, rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  assign signed_div = (op == MDU_DIV);
  assign mag_a      = a[31] ? (32'd0 - a) : a;
  assign mag_b      = b[31] ? (32'd0 - b) : b;
  assign num        = signed_div ? mag_a : a;
  assign den        = signed_div ? mag_b : b;
  assign den_safe   = (den == 32'd0) ? 32'd1 : den;
  assign quo        = num / den_safe;
  assign rem        = num % den_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    div0   = 1'b0;
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        div0   = (b == 32'd0);
        res_lo = (signed_div && (a[31] ^ b[31])) ? (32'd0 - quo) : quo;
        res_hi = (signed_div && a[31]) ? (32'd0 - rem) : rem;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU controller: busy-window FSM, shadow result, HI/LO registers and D-stage stall.
// Optional macro MDU_CANCEL_EN: an exception during BUSY aborts the in-flight operation.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  mdu_state_e  state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] shadow_hi, shadow_lo;
  logic        shadow_div0;
  logic [31:0] res_hi, res_lo;
  logic        res_div0;
  logic        is_mul, is_div, start, commit, cancel;

  mdu_arith u_arith (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .div0   (res_div0)
  );

  assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
  assign is_div = (op == MDU_DIV)  || (op == MDU_DIVU);
  assign start  = (state == ST_IDLE) && !req && (is_mul || is_div);

`ifdef MDU_CANCEL_EN
  assign cancel = req;
`else
  assign cancel = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_BUSY;
          cnt_next   = is_div ? 4'(DIV_LAT) : 4'(MUL_LAT);
        end
      end
      ST_BUSY: begin
        if (cancel) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_hi   <= 32'd0;
      shadow_lo   <= 32'd0;
      shadow_div0 <= 1'b0;
    end else if (start) begin
      shadow_hi   <= res_hi;
      shadow_lo   <= res_lo;
      shadow_div0 <= res_div0;
    end
  end

  // A zero divisor still runs the full window but never commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (commit) begin
      if (!shadow_div0) begin
        hi <= shadow_hi;
        lo <= shadow_lo;
      end
    end else if ((state == ST_IDLE) && !req) begin
      if (op == MDU_MTHI) hi <= a;
      if (op == MDU_MTLO) lo <= a;
    end
  end

  assign busy  = (state == ST_BUSY);
  assign stall = d_is_md & (busy | start);
  assign rdata = (op == MDU_MFHI) ? hi : lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops against an arithmetic reference.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        req, d_is_md;
  logic        busy, stall;
  logic [31:0] hi, lo, rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .a       (a),
    .b       (b),
    .req     (req),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .rdata   (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Architectural result of an arithmetic op, from plain 64-bit arithmetic.
  task automatic ref_model(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (o)
      MDU_MULT: begin
        p = 64'(sa * sb);
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      MDU_MULTU: begin
        p = {32'd0, av} * {32'd0, bv};
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      MDU_DIV: if (bv != 32'd0) begin
        q = sa / sb; r = sa % sb;
        exp_lo = q[31:0]; exp_hi = r[31:0];
      end
      MDU_DIVU: if (bv != 32'd0) begin
        exp_lo = av / bv; exp_hi = av % bv;
      end
      default: ;
    endcase
  endtask

  // Issues an arithmetic op and follows it through its busy window; iop/ireq are injected in busy cycle 2.
  task automatic run_md(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic dmd, input logic [3:0] iop, input logic ireq);
    int lat;
    lat = (o == MDU_DIV || o == MDU_DIVU) ? DIV_LAT : MUL_LAT;
    op = o; a = av; b = bv; req = 1'b0; d_is_md = dmd;
    #1;
    check("start_stall", {31'd0, stall}, {31'd0, dmd});
    check("start_busy", {31'd0, busy}, 32'd0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      op  = (i == 2) ? iop : MDU_NONE;
      req = (i == 2) ? ireq : 1'b0;
      a   = 32'hDEAD_BEEF;
      #1;
      check("win_busy", {31'd0, busy}, 32'd1);
      check("win_stall", {31'd0, stall}, {31'd0, dmd});
      check("win_hi", hi, exp_hi);
      check("win_lo", lo, exp_lo);
`ifdef MDU_CANCEL_EN
      if (i == 2 && ireq) begin
        @(negedge clk);
        op = MDU_NONE; req = 1'b0;
        #1;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_hi", hi, exp_hi);
        check("cancel_lo", lo, exp_lo);
        $display("txn op=%0d a=%h b=%h cancelled hi=%h lo=%h", o, av, bv, hi, lo);
        return;
      end
`endif
    end
    @(negedge clk);
    op = MDU_NONE; req = 1'b0;
    #1;
    ref_model(o, av, bv);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_hi", hi, exp_hi);
    check("done_lo", lo, exp_lo);
    $display("txn op=%0d a=%h b=%h hi=%h lo=%h", o, av, bv, hi, lo);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] av, input logic rq);
    op = o; a = av; req = rq; d_is_md = 1'b0;
    #1;
    check("mt_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    op = MDU_NONE; req = 1'b0;
    #1;
    if (!rq) begin
      if (o == MDU_MTHI) exp_hi = av;
      else exp_lo = av;
    end
    check("mt_hi", hi, exp_hi);
    check("mt_lo", lo, exp_lo);
    $display("txn op=%0d a=%h req=%0d hi=%h lo=%h", o, av, rq, hi, lo);
  endtask

  initial begin
    logic [31:0] av, bv;
    int sel;
    reset = 1'b0; op = MDU_NONE; a = 32'd0; b = 32'd0; req = 1'b0; d_is_md = 1'b1;
    @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;

    run_md(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, MDU_NONE, 1'b0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    run_md(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, MDU_NONE, 1'b0);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    run_md(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, MDU_NONE, 1'b0);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);
    run_md(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, MDU_NONE, 1'b0);
    check("divovf_hi", hi, 32'd0);
    check("divovf_lo", lo, 32'h8000_0000);

    mt(MDU_MTHI, 32'h11, 1'b0);
    mt(MDU_MTLO, 32'h22, 1'b0);
    run_md(MDU_DIVU, 32'h1234_5678, 32'd0, 1'b0, MDU_NONE, 1'b0);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    mt(MDU_MTHI, 32'h1234, 1'b1);
    check("mthi_req_hi", hi, 32'h11);
    mt(MDU_MTHI, 32'h1234, 1'b0);
    check("mthi_hi", hi, 32'h1234);

    op = MDU_MFHI;
    #1 check("mfhi", rdata, exp_hi);
    op = MDU_MFLO;
    #1 check("mflo", rdata, exp_lo);
    op = MDU_NONE;

    run_md(MDU_MULT, 32'd7, 32'd9, 1'b0, MDU_MTLO, 1'b0);
    run_md(MDU_MULTU, 32'd3, 32'd5, 1'b1, MDU_MTHI, 1'b0);
    run_md(MDU_MULT, 32'h0001_0000, 32'h0003_0000, 1'b1, MDU_NONE, 1'b1);

    // Reset asserted in busy cycle 3 of a divide.
    op = MDU_DIV; a = 32'd100; b = 32'd7; req = 1'b0; d_is_md = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      op = MDU_NONE;
    end
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      @(negedge clk);
      #1;
      check("postrst_busy", {31'd0, busy}, 32'd0);
      check("postrst_lo", lo, 32'd0);
    end
    $display("txn reset mid-div hi=%h lo=%h", hi, lo);

    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(0, 5));
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 7) == 0) bv = 32'd0;
      if ($urandom_range(0, 7) == 0) bv = 32'hFFFF_FFFF;
      case (sel)
        0: run_md(MDU_MULT,  av, bv, 1'($urandom_range(0, 1)), MDU_NONE, 1'b0);
        1: run_md(MDU_MULTU, av, bv, 1'($urandom_range(0, 1)), MDU_NONE, 1'b0);
        2: run_md(MDU_DIV,   av, bv, 1'($urandom_range(0, 1)), MDU_NONE, 1'b0);
        3: run_md(MDU_DIVU,  av, bv, 1'($urandom_range(0, 1)), MDU_NONE, 1'b0);
        4: mt(MDU_MTHI, av, 1'($urandom_range(0, 1)));
        default: mt(MDU_MTLO, av, 1'($urandom_range(0, 1)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
